// File: rtl/iris_argmax_classifier_if.sv
// Score-in / class-out handshake bundle for the Iris argmax stage.
// margin exists only when ARGMAX_MARGIN_EN is defined.
interface iris_argmax_classifier_if #(
  parameter int DATA_WIDTH = 8,
  parameter int N_CLASSES  = 3
);
  localparam int IDX_W = $clog2(N_CLASSES);

  logic                            in_valid;
  logic                            in_ready;
  logic [N_CLASSES*DATA_WIDTH-1:0] scores;
  logic                            out_valid;
  logic                            out_ready;
  logic [IDX_W-1:0]                class_idx;
  logic signed [DATA_WIDTH-1:0]    best_score;
`ifdef ARGMAX_MARGIN_EN
  logic [DATA_WIDTH:0]             margin;
`endif

  modport master (
    output in_valid, scores, out_ready,
    input  in_ready, out_valid, class_idx, best_score
`ifdef ARGMAX_MARGIN_EN
    , input margin
`endif
  );

  modport slave (
    input  in_valid, scores, out_ready,
    output in_ready, out_valid, class_idx, best_score
`ifdef ARGMAX_MARGIN_EN
    , output margin
`endif
  );
endinterface

// File: rtl/iris_argmax_classifier.sv
// Sequential argmax over signed output-layer scores, one compare per cycle.
// Optional ARGMAX_MARGIN_EN adds second-best tracking and the margin output.
module iris_argmax_classifier #(
  parameter int DATA_WIDTH = 8,
  parameter int N_CLASSES  = 3
) (
  input logic clk,
  input logic rst,
  input logic En,
  iris_argmax_classifier_if.slave bus
);
  localparam int IDX_W = $clog2(N_CLASSES);
  localparam int SW    = N_CLASSES * DATA_WIDTH;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_CLASSES - 1);
  localparam logic [IDX_W-1:0] ONE  = IDX_W'(1);

  logic [1:0]                   state_q, state_d;
  logic [SW-1:0]                scores_q, scores_d;
  logic [IDX_W-1:0]             i_q, i_d;
  logic [IDX_W-1:0]             idx_q, idx_d;
  logic signed [DATA_WIDTH-1:0] best_q, best_d;
  logic [IDX_W-1:0]             cls_q, cls_d;
  logic signed [DATA_WIDTH-1:0] bsc_q, bsc_d;

  logic signed [DATA_WIDTH-1:0] s;
  logic signed [DATA_WIDTH-1:0] step_best;
  logic [IDX_W-1:0]             step_idx;

`ifdef ARGMAX_MARGIN_EN
  localparam logic signed [DATA_WIDTH-1:0] MIN_S =
    {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic signed [DATA_WIDTH-1:0] second_q, second_d;
  logic signed [DATA_WIDTH-1:0] step_second;
  logic [DATA_WIDTH:0]          mrg_q, mrg_d;
  logic [DATA_WIDTH:0]          diff;
`endif

  assign s = scores_q[int'(i_q)*DATA_WIDTH +: DATA_WIDTH];

  // Strict compare: an equal score never displaces best, so lowest index wins.
  always_comb begin
    step_best = best_q;
    step_idx  = idx_q;
`ifdef ARGMAX_MARGIN_EN
    step_second = second_q;
`endif
    if (s > best_q) begin
      step_best = s;
      step_idx  = i_q;
`ifdef ARGMAX_MARGIN_EN
      step_second = best_q;
    end else if (s > second_q) begin
      step_second = s;
`endif
    end
  end

`ifdef ARGMAX_MARGIN_EN
  assign diff = {step_best[DATA_WIDTH-1], step_best}
              - {step_second[DATA_WIDTH-1], step_second};
`endif

  always_comb begin
    state_d  = state_q;
    scores_d = scores_q;
    i_d      = i_q;
    idx_d    = idx_q;
    best_d   = best_q;
    cls_d    = cls_q;
    bsc_d    = bsc_q;
`ifdef ARGMAX_MARGIN_EN
    second_d = second_q;
    mrg_d    = mrg_q;
`endif
    if (En) begin
      unique case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            scores_d = bus.scores;
            best_d   = bus.scores[DATA_WIDTH-1:0];
            idx_d    = '0;
            i_d      = ONE;
`ifdef ARGMAX_MARGIN_EN
            second_d = MIN_S;
`endif
            state_d  = SCAN;
          end
        end
        SCAN: begin
          best_d = step_best;
          idx_d  = step_idx;
          i_d    = i_q + ONE;
`ifdef ARGMAX_MARGIN_EN
          second_d = step_second;
`endif
          if (i_q == LAST) begin
            cls_d   = step_idx;
            bsc_d   = step_best;
`ifdef ARGMAX_MARGIN_EN
            mrg_d   = diff;
`endif
            state_d = DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      scores_q <= '0;
      i_q      <= '0;
      idx_q    <= '0;
      best_q   <= '0;
      cls_q    <= '0;
      bsc_q    <= '0;
`ifdef ARGMAX_MARGIN_EN
      second_q <= '0;
      mrg_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      scores_q <= scores_d;
      i_q      <= i_d;
      idx_q    <= idx_d;
      best_q   <= best_d;
      cls_q    <= cls_d;
      bsc_q    <= bsc_d;
`ifdef ARGMAX_MARGIN_EN
      second_q <= second_d;
      mrg_q    <= mrg_d;
`endif
    end
  end

  assign bus.in_ready   = (state_q == IDLE);
  assign bus.out_valid  = (state_q == DONE);
  assign bus.class_idx  = cls_q;
  assign bus.best_score = bsc_q;
`ifdef ARGMAX_MARGIN_EN
  assign bus.margin     = mrg_q;
`endif
endmodule

// File: doc/iris_argmax_classifier.md
# iris_argmax_classifier

Final stage of the Iris network: consumes the signed scores of the output-layer neurons and reports the index of the largest one. Scores are captured on a valid/ready handshake and scanned sequentially, one comparison per cycle. The result is held on a registered output port with its own valid/ready handshake, so the layer controller can stall it.

## Interface
Parameters:
- DATA_WIDTH, 8, width of each signed score, matching the neuron Y width.
- N_CLASSES, 3, number of scores; legal range 2..16.
- IDX_W, $clog2(N_CLASSES), width of the class index (derived, not overridden).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- En  in  1  global enable; when low, all state and registers freeze.
- in_valid  in  1  the scores bus holds a complete output-layer result.
- in_ready  out  1  high exactly when the FSM is in IDLE.
- scores  in  N_CLASSES*DATA_WIDTH  packed signed scores; class k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- out_valid  out  1  result valid, high exactly in DONE.
- out_ready  in  1  downstream accepts the result.
- class_idx  out  IDX_W  index of the maximum score.
- best_score  out  DATA_WIDTH  signed maximum score.
- margin  out  DATA_WIDTH+1  unsigned best minus second-best score; present only with the macro defined.

## Operation
- States: IDLE, SCAN, DONE.
- IDLE:
  - If En && in_valid, capture all scores into internal registers.
  - Set best = score[0], idx = 0, second = -2^(DATA_WIDTH-1), i = 1. Go to SCAN.
- SCAN, each enabled cycle, compare s = score_reg[i]:
  - If s > best (strict signed compare): second <= best, best <= s, idx <= i.
  - Else if s > second: second <= s.
  - Then i <= i+1.
  - When i == N_CLASSES-1 is processed, load the output registers (class_idx, best_score, margin) and go to DONE.
- Tie rule: an equal score never replaces best, so the lowest index wins.
- DONE:
  - out_valid = 1. Outputs remain stable while out_ready is low.
  - On En && out_ready, go to IDLE. class_idx, best_score and margin keep their last values after leaving DONE.
- in_valid is ignored outside IDLE. The input bus may change freely after capture.
- margin = best − second, computed in DATA_WIDTH+1 bits, so it is always ≥ 0 and cannot overflow.

## Timing
- Reset values: state IDLE; in_ready 1; out_valid 0; class_idx 0; best_score 0; margin 0; internal registers 0.
- Latency: with the capture at edge 0, out_valid rises after edge N_CLASSES-1 (after edge 2 for Iris).
- Throughput: one result per N_CLASSES+1 cycles when out_ready is held high, counting the capture cycle, the scan cycles, DONE and the return to IDLE.
- En low: no state or register changes and the handshakes do not complete. in_ready and out_valid still reflect the current state.
- Reset mid-SCAN or mid-DONE:
  - Immediate return to IDLE with all outputs at their reset values.
  - The in-flight result is discarded and not re-emitted.
- A handshake happening together with reset release is ignored. The first capture can occur on the edge after rst deasserts.

## Configuration
- ARGMAX_MARGIN_EN defined:
  - The second-best tracking register and the margin port exist.
  - margin is updated on entry to DONE.
- ARGMAX_MARGIN_EN undefined:
  - The margin port and the second-best logic are absent.
  - class_idx, best_score and all timing are unchanged.

## Test plan
- Basic argmax:
  - Stimulus: scores (5, 12, -3), in_valid pulse, out_ready=1.
  - Response: class_idx=1, best_score=12, margin=7; out_valid rises exactly 2 edges after capture.
- Tie:
  - Stimulus: scores (9, 9, 2).
  - Response: class_idx=0, best_score=9, margin=0.
- All negative:
  - Stimulus: scores (-8, -3, -128).
  - Response: class_idx=1, best_score=-3, margin=5.
- Backpressure:
  - Stimulus: out_ready held low for 5 cycles in DONE, with in_valid pulsed meanwhile carrying (0, 0, 100).
  - Response: outputs stable and in_ready=0 throughout; the pulse is not captured. After out_ready rises, in_ready=1 on the next cycle.
- Reset mid-SCAN:
  - Stimulus: assert rst one cycle after capturing (1, 50, 2).
  - Response: out_valid=0, class_idx=0 and best_score=0 immediately. No result appears after rst is released until a new capture.
- Enable freeze:
  - Stimulus: drop En for 3 cycles during SCAN.
  - Response: the result is unchanged and out_valid is delayed by exactly 3 cycles.
